// File: rtl/i2c_master_tx_if.sv
// i2c_master_tx_if: host-side request/status bundle of the I2C master transmitter.
interface i2c_master_tx_if #(parameter int NUM_BYTES = 33);
  logic [8*NUM_BYTES-1:0] data_in;
  logic send;
  logic busy;
  logic done;
  logic nack_err;
  logic arb_lost;
  modport master (output data_in, send, input busy, done, nack_err, arb_lost);
  modport slave (input data_in, send, output busy, done, nack_err, arb_lost);
endinterface

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: I2C write master sending START, {SLAVE_ADDR,0}, NUM_BYTES payload bytes MSB-first, STOP; define I2C_MASTER_ARB_EN for arbitration-loss detection.
module i2c_master_tx #(
  parameter int CLK_DIV = 125,
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int NUM_BYTES = 33
) (
  input logic clk,
  input logic reset,
  i2c_master_tx_if.slave host,
  output logic scl,
  inout wire sda
);
  localparam int QW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NUM_BYTES + 1);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;
  state_t state, state_n;
  logic [QW-1:0] qcnt;
  logic [1:0] q;
  logic [2:0] bit_idx;
  logic [BW-1:0] byte_idx;
  logic [8*NUM_BYTES-1:0] pay;
  logic [1:0] sda_s;
  logic [7:0] cur_byte;
  logic sda_low, nack_q, busy, accept, tick, end_q2, end_bit, bit_val, last_byte, arb_hit;
  assign busy = state != IDLE && state != DONE;
  assign accept = state == IDLE && host.send;
  assign tick = qcnt == QW'(CLK_DIV - 1);
  assign end_q2 = tick && q == 2'd2;
  assign end_bit = tick && q == 2'd3;
  assign cur_byte = byte_idx == '0 ? {SLAVE_ADDR, 1'b0} : pay[8*NUM_BYTES-1 -: 8];
  assign bit_val = cur_byte[bit_idx];
  assign last_byte = byte_idx == BW'(NUM_BYTES);
  assign sda = sda_low ? 1'b0 : 1'bz;
  assign host.busy = busy;
  assign host.done = state == DONE;
  assign host.nack_err = nack_q;
`ifdef I2C_MASTER_ARB_EN
  logic arb_q;
  // We released SDA for a 1 but the line reads 0: another master owns the bus.
  assign arb_hit = state == BIT && end_q2 && bit_val && !sda_s[1];
  always_ff @(posedge clk)
    if (reset || accept) arb_q <= 1'b0;
    else if (arb_hit) arb_q <= 1'b1;
  assign host.arb_lost = arb_q;
`else
  assign arb_hit = 1'b0;
  assign host.arb_lost = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt <= '0;
      q <= '0;
      bit_idx <= 3'd7;
      byte_idx <= '0;
      nack_q <= 1'b0;
      sda_s <= 2'b11;
    end else begin
      sda_s <= {sda_s[0], sda};
      qcnt <= (!busy || tick) ? '0 : qcnt + 1'b1;
      if (accept) begin
        q <= '0;
        bit_idx <= 3'd7;
        byte_idx <= '0;
        nack_q <= 1'b0;
        pay <= host.data_in;
      end else if (tick) begin
        q <= q + 2'd1;
        if (state == BIT && end_bit) bit_idx <= bit_idx - 3'd1;
        if (state == ACK && end_q2 && sda_s[1]) nack_q <= 1'b1;
        // Byte 0 is the address, so the payload only starts shifting after byte 1.
        if (state == ACK && end_bit && !nack_q && !last_byte) begin
          byte_idx <= byte_idx + 1'b1;
          if (byte_idx != '0) pay <= pay << 8;
        end
      end
    end
  end
  always_comb begin
    state_n = state;
    scl = 1'b1;
    sda_low = 1'b0;
    case (state)
      IDLE: state_n = host.send ? START : IDLE;
      START: begin
        scl = q != 2'd3;
        sda_low = q[1];
        state_n = end_bit ? BIT : START;
      end
      BIT: begin
        scl = q[1];
        sda_low = !bit_val;
        state_n = arb_hit ? DONE : (end_bit && bit_idx == 3'd0) ? ACK : BIT;
      end
      ACK: begin
        scl = q[1];
        state_n = !end_bit ? ACK : (nack_q || last_byte) ? STOP : BIT;
      end
      STOP: begin
        scl = q != 2'd0;
        sda_low = q != 2'd3;
        state_n = end_bit ? DONE : STOP;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: scenario table plus scoreboarded bus monitor / ACKing slave model for i2c_master_tx.
module tb_i2c_master_tx;
  localparam int N = 33;
  localparam int DIV = 8;
  typedef struct {
    string name;
    int nack_at;
    bit disturb;
    int exp_bytes;
    bit exp_nack;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl;
  logic slave_low = 1'b0;
  logic arb_low = 1'b0;
  wire sda;
  pullup (sda);
  assign sda = (slave_low || arb_low) ? 1'b0 : 1'bz;
  i2c_master_tx_if #(.NUM_BYTES(N)) host ();
  i2c_master_tx #(.CLK_DIV(DIV), .NUM_BYTES(N)) dut (
    .clk(clk), .reset(reset), .host(host.slave), .scl(scl), .sda(sda)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int starts = 0, stops = 0, rises = 0, dones = 0, bytes_seen = 0, xfer_bytes = 0, bitcnt = 0;
  int nack_at = -1;
  logic [7:0] shreg = '0;
  logic ps = 1'b1, pd = 1'b1;
  logic [7:0] sb[$];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask
  // Bus monitor and slave: decodes START/STOP/bytes, pops the scoreboard per byte, drives ACK.
  initial forever begin
    @(negedge clk);
    if (host.done) dones++;
    if (ps && scl && pd && !sda) begin
      starts++;
      bitcnt = 0;
      xfer_bytes = 0;
    end
    if (ps && scl && !pd && sda) begin
      stops++;
      if (bitcnt == 1) rises--;
      bitcnt = 0;
    end
    if (!ps && scl) begin
      rises++;
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], sda};
        bitcnt++;
        if (bitcnt == 8) begin
          if (sb.size() == 0) chk("extra_byte", sb.size(), 1);
          else chk("wire_byte", shreg, sb.pop_front());
          bytes_seen++;
          xfer_bytes++;
        end
      end else bitcnt = 0;
    end
    if (ps && !scl) slave_low = bitcnt == 8 && xfer_bytes - 1 != nack_at;
    ps = scl;
    pd = sda;
  end
  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic load_payload();
    for (int k = 0; k < N; k++) host.data_in[8*N-1-8*k -: 8] = 8'(k);
  endtask
  task automatic push_expected(input int n);
    sb.push_back(8'hD4);
    for (int k = 0; k < n - 1; k++) sb.push_back(8'(k));
  endtask
  task automatic send_pulse();
    host.send = 1'b1;
    @(negedge clk);
    host.send = 1'b0;
    chk("accept_busy", host.busy, 1);
    chk("accept_nack_clear", host.nack_err, 0);
    chk("accept_arb_clear", host.arb_lost, 0);
  endtask
  task automatic wait_done(input bit disturb, output int busy_low);
    int cyc = 0;
    busy_low = 0;
    while (!host.done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 2000) begin
        host.send = 1'b1;
        host.data_in = ~host.data_in;
      end
      if (disturb && cyc == 2001) host.send = 1'b0;
      if (!host.done && !host.busy) busy_low++;
    end
    chk("done_within_budget", int'(cyc < 20000), 1);
  endtask
  task automatic wait_scl(input logic level);
    int cyc = 0;
    while (scl != level && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("scl_wait", scl, level);
  endtask
  task automatic reset_mid_byte();
    int b0 = bytes_seen;
    int p0;
    int cyc = 0;
    nack_at = -1;
    load_payload();
    push_expected(N + 1);
    send_pulse();
    while (bytes_seen - b0 < 10 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_byte10", bytes_seen - b0, 10);
    wait_scl(1'b0);
    wait_scl(1'b1);
    wait_scl(1'b0);
    wait_scl(1'b1);
    wait_scl(1'b0);
    p0 = stops;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_scl", scl, 1);
    chk("rst_mid_sda", sda, 1);
    chk("rst_mid_busy", host.busy, 0);
    chk("rst_mid_done", host.done, 0);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_no_stop", stops - p0, 0);
    chk("rst_mid_idle", host.busy, 0);
    sb.delete();
  endtask
  task automatic done_cycle_send();
    int s0 = starts;
    int bl;
    nack_at = 0;
    sb.push_back(8'hD4);
    sb.push_back(8'hD4);
    send_pulse();
    wait_done(1'b0, bl);
    host.send = 1'b1;
    @(negedge clk);
    chk("done_cycle_send_ignored", host.busy, 0);
    @(negedge clk);
    host.send = 1'b0;
    chk("send_after_done_accepted", host.busy, 1);
    wait_done(1'b0, bl);
    @(negedge clk);
    chk("two_xfer_starts", starts - s0, 2);
    chk("two_xfer_sb_left", sb.size(), 0);
  endtask
`ifdef I2C_MASTER_ARB_EN
  task automatic arbitration();
    int r0 = rises;
    int p0, d0, bl;
    int cyc = 0;
    nack_at = -1;
    sb.delete();
    send_pulse();
    while (rises == r0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    arb_low = 1'b1;
    p0 = stops;
    d0 = dones;
    wait_done(1'b0, bl);
    chk("arb_lost", host.arb_lost, 1);
    chk("arb_scl_high", scl, 1);
    @(negedge clk);
    chk("arb_idle", host.busy, 0);
    chk("arb_done_once", dones - d0, 1);
    chk("arb_no_stop", stops - p0, 0);
    arb_low = 1'b0;
    @(negedge clk);
    chk("arb_sda_released", sda, 1);
  endtask
`endif
  initial begin
    vec_t tab[4];
    int s0, p0, r0, b0, d0, bl;
    tab[0] = '{"full_busy_protect", -1, 1'b1, N + 1, 1'b0};
    tab[1] = '{"addr_nack", 0, 1'b0, 1, 1'b1};
    tab[2] = '{"data_nack", 6, 1'b0, 7, 1'b1};
    tab[3] = '{"full_after_reset", -1, 1'b0, N + 1, 1'b0};
    host.send = 1'b0;
    load_payload();
    repeat (3) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", host.busy, 0);
    chk("rst_done", host.done, 0);
    chk("rst_nack", host.nack_err, 0);
    chk("rst_arb", host.arb_lost, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset_mid_byte();
      nack_at = tab[i].nack_at;
      load_payload();
      s0 = starts;
      p0 = stops;
      r0 = rises;
      b0 = bytes_seen;
      d0 = dones;
      push_expected(tab[i].exp_bytes);
      send_pulse();
      wait_done(tab[i].disturb, bl);
      chk({tab[i].name, "_nack"}, host.nack_err, tab[i].exp_nack);
      @(negedge clk);
      chk({tab[i].name, "_done_width"}, host.done, 0);
      repeat (4) @(negedge clk);
      chk({tab[i].name, "_done_count"}, dones - d0, 1);
      chk({tab[i].name, "_bytes"}, bytes_seen - b0, tab[i].exp_bytes);
      chk({tab[i].name, "_sb_left"}, sb.size(), 0);
      chk({tab[i].name, "_starts"}, starts - s0, 1);
      chk({tab[i].name, "_stops"}, stops - p0, 1);
      chk({tab[i].name, "_scl_rises"}, rises - r0, 9 * tab[i].exp_bytes);
      chk({tab[i].name, "_busy_gaps"}, bl, 0);
      chk({tab[i].name, "_arb"}, host.arb_lost, 0);
    end
    done_cycle_send();
`ifdef I2C_MASTER_ARB_EN
    arbitration();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
